// File: rtl/sync_fifo_flags.sv
// ============================================================================
// Module   : sync_fifo_flags
// Purpose  : Single-clock FIFO with occupancy count, almost-full/empty
//            thresholds and sticky overflow/underflow flags.
// Option   : SYNC_FIFO_FWFT_EN selects first-word-fall-through read mode.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo_flags #(
  parameter int DEPTH     = 16,
  parameter int PTRWIDTH  = 4,
  parameter int DWIDTH    = 8,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [DWIDTH-1:0]   wdata,
  output logic                full,
  output logic                almost_full,
  input  logic                pop,
  output logic [DWIDTH-1:0]   rdata,
  output logic                rvalid,
  output logic                empty,
  output logic                almost_empty,
  output logic [PTRWIDTH:0]   count,
  output logic                overflow,
  output logic                underflow,
  input  logic                err_clr
);

  localparam logic [PTRWIDTH:0] c_depth  = (PTRWIDTH+1)'(DEPTH);
  localparam logic [PTRWIDTH:0] c_afull  = (PTRWIDTH+1)'(AFULL_TH);
  localparam logic [PTRWIDTH:0] c_aempty = (PTRWIDTH+1)'(AEMPTY_TH);
  localparam logic [PTRWIDTH:0] c_one    = (PTRWIDTH+1)'(1);
  localparam logic [PTRWIDTH:0] c_zero   = '0;

  logic [DWIDTH-1:0]  r_mem [DEPTH];
  logic [PTRWIDTH:0]  r_wrptr;
  logic [PTRWIDTH:0]  r_rdptr;
  logic [PTRWIDTH:0]  r_count;
  logic               r_overflow;
  logic               r_underflow;

  logic               w_full;
  logic               w_empty;
  logic               w_push_acc;
  logic               w_pop_acc;

  // Flags decode only the registered count, so they lag the causing edge.
  assign w_full       = (r_count == c_depth);
  assign w_empty      = (r_count == c_zero);
  assign w_push_acc   = push && !w_full;
  assign w_pop_acc    = pop && !w_empty;

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= c_afull);
  assign almost_empty = (r_count <= c_aempty);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrptr     <= c_zero;
      r_rdptr     <= c_zero;
      r_count     <= c_zero;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_acc) r_wrptr <= r_wrptr + c_one;
      if (w_pop_acc)  r_rdptr <= r_rdptr + c_one;

      if (w_push_acc && !w_pop_acc)
        r_count <= r_count + c_one;
      else if (!w_push_acc && w_pop_acc)
        r_count <= r_count - c_one;

      // A new error outranks a coincident clear.
      if (push && w_full)
        r_overflow <= 1'b1;
      else if (err_clr)
        r_overflow <= 1'b0;

      if (pop && w_empty)
        r_underflow <= 1'b1;
      else if (err_clr)
        r_underflow <= 1'b0;
    end
  end

  // Storage is left uncleared on reset; the pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (!reset && w_push_acc)
      r_mem[r_wrptr[PTRWIDTH-1:0]] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata  = r_mem[r_rdptr[PTRWIDTH-1:0]];
  assign rvalid = !w_empty;
`else
  logic [DWIDTH-1:0]  r_rdata;
  logic               r_rvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_pop_acc;
      if (w_pop_acc)
        r_rdata <= r_mem[r_rdptr[PTRWIDTH-1:0]];
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
`endif

endmodule

`default_nettype wire
